uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised successor to the single-byte UART transmitter: serialises configurable-width characters (5–9 data bits, optional parity, 1 or 2 stop bits) from an internal FIFO, so hosts can queue several characters with a ready/valid handshake instead of waiting per byte. It sits between the SoC bus-side peripheral registers and the TX pad, in the same clock domain as the existing UART receive path.

## Interface
- CLKS_PER_BIT, 87, clock cycles per serial bit; must be ≥ 2
- DATA_BITS, 8, data bits per frame; legal range 5–9
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd; honoured only with UART_TX_PARITY_EN
- FIFO_DEPTH, 4, character FIFO depth; power of two, ≥ 2
- i_Clock  in  1  system clock; all logic on rising edge
- i_Reset  in  1  asynchronous, active-low reset
- i_Tx_DV  in  1  write strobe; character accepted on an edge where i_Tx_DV && o_Tx_Ready
- i_Tx_Byte  in  DATA_BITS  character to queue
- o_Tx_Ready  out  1  FIFO not full
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  characters queued, excluding the one in flight
- o_Tx_Active  out  1  high while a frame is on the line
- o_Tx_Serial  out  1  serial line, idle high
- o_Tx_Done  out  1  one-cycle pulse per completed frame

## Operation
- Reset (async assert, sync-safe release): FIFO emptied, FSM → IDLE, bit/clock counters 0; o_Tx_Serial=1, o_Tx_Ready=1, o_Fifo_Count=0, o_Tx_Active=0, o_Tx_Done=0. A frame in progress is aborted; the line goes high immediately.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if FIFO non-empty, pop head into shift register, o_Tx_Serial←0, o_Tx_Active←1, → START.
- START: hold 0 for CLKS_PER_BIT cycles → DATA.
- DATA: DATA_BITS bits, LSB first, each CLKS_PER_BIT cycles; after last bit → PARITY if enabled, else STOP.
- PARITY: even = XOR of data bits; odd = its inverse; one bit time → STOP.
- STOP: line high for STOP_BITS×CLKS_PER_BIT cycles. On the final cycle: o_Tx_Done←1 for the next cycle only. If FIFO non-empty, pop and go directly to START (no idle gap, o_Tx_Active stays 1); else o_Tx_Active←0, → IDLE.
- Clock counter width $clog2(CLKS_PER_BIT); bit index width $clog2(DATA_BITS+1); no wrap beyond terminal counts.
- FIFO: write when i_Tx_DV && o_Tx_Ready; writes while full are dropped, with no other effect. A simultaneous write and pop leaves count unchanged. o_Tx_Ready and o_Fifo_Count are registered and reflect state after the previous edge.
- The character in flight is held in the shift register. Its FIFO slot is freed on the pop edge.

## Timing
- Empty FIFO, idle: write on edge E0; the pop occurs on E1 and o_Tx_Serial=0 from E1. This is one cycle of latency.
- Frame length: (1 + DATA_BITS + P + STOP_BITS)×CLKS_PER_BIT cycles, where P=1 if parity is active.
- Back-to-back frames are exactly contiguous.
- o_Tx_Done is high for exactly one cycle, the cycle after the final stop-bit cycle. This coincides with the next start bit if a frame is queued.

## Configuration
- UART_TX_PARITY_EN defined: PARITY parameter honoured; PARITY state and parity generator present.
- Not defined: PARITY ignored; no parity bit is transmitted; PARITY state and logic are absent.

## Test plan
- CLKS_PER_BIT=4, DATA_BITS=8, PARITY=1, macro on; write 0xA5 → line 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. Each bit lasts 4 cycles; Done pulses once at cycle 44 after pop.
- PARITY=2, write 0x07 → parity bit 0. Macro off with the same stimulus → no parity bit; frame is 40 cycles.
- FIFO_DEPTH=4: 6 writes on consecutive cycles → first pops after one cycle, so 5 accepted. o_Tx_Ready drops after the 5th, the 6th is dropped, and 5 frames go out contiguously with o_Tx_Active never deasserting.
- DATA_BITS=7, STOP_BITS=2, write 0x55 → 7 data bits then 8 high cycles; the MSB of the 7-bit field is sent last.
- Assert reset in mid-DATA with 2 queued → line high the same cycle, o_Fifo_Count=0, no Done pulse. After release, the line stays idle until a new write.
- Write on the final STOP cycle with FIFO empty → next frame starts after a one-cycle IDLE gap. Done pulses once.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Host-side character queue handshake for uart_tx_fifo: write strobe and data in,
// FIFO ready and occupancy out.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 i_Tx_DV;
    logic [DATA_BITS-1:0] i_Tx_Byte;
    logic                 o_Tx_Ready;
    logic [CW-1:0]        o_Fifo_Count;

    modport master (output i_Tx_DV, i_Tx_Byte, input  o_Tx_Ready, o_Fifo_Count);
    modport slave  (input  i_Tx_DV, i_Tx_Byte, output o_Tx_Ready, o_Fifo_Count);
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter: 5-9 data bits, 1-2 stop bits, back-to-back frames.
// Define UART_TX_PARITY_EN to build the parity state and generator (PARITY 1 even, 2 odd).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           i_Clock,
    input  logic           i_Reset,
    uart_tx_fifo_if.slave  tx,
    output logic           o_Tx_Active,
    output logic           o_Tx_Serial,
    output logic           o_Tx_Done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int KW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
    localparam logic [KW-1:0] CLK_LAST  = KW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ---------------- character FIFO ----------------
    logic [DATA_BITS-1:0] r_Mem [FIFO_DEPTH];
    logic [AW-1:0]        r_Wr_Ptr, r_Rd_Ptr;
    logic [CW-1:0]        r_Count;
    logic                 r_Ready;
    logic                 w_Push, w_Pop;
    logic [CW-1:0]        w_Count_Nxt;
    logic [DATA_BITS-1:0] w_Head;

    assign w_Push = tx.i_Tx_DV && r_Ready;
    assign w_Head = r_Mem[r_Rd_Ptr];

    always_comb begin
        w_Count_Nxt = r_Count;
        if (w_Push && !w_Pop)
            w_Count_Nxt = r_Count + 1'b1;
        else if (!w_Push && w_Pop)
            w_Count_Nxt = r_Count - 1'b1;
    end

    always_ff @(posedge i_Clock) begin
        if (w_Push)
            r_Mem[r_Wr_Ptr] <= tx.i_Tx_Byte;
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_Wr_Ptr <= '0;
            r_Rd_Ptr <= '0;
            r_Count  <= '0;
            r_Ready  <= 1'b1;
        end else begin
            if (w_Push) r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
            if (w_Pop)  r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
            r_Count <= w_Count_Nxt;
            r_Ready <= (w_Count_Nxt != FULL);
        end
    end

    // ---------------- frame FSM ----------------
    state_t               r_State, w_State_Nxt;
    logic [KW-1:0]        r_Clk_Cnt, w_Clk_Nxt;
    logic [BW-1:0]        r_Bit_Idx, w_Bit_Nxt;
    logic [DATA_BITS-1:0] r_Shift, w_Shift_Nxt;
    logic                 r_Serial, w_Serial_Nxt;
    logic                 r_Active, w_Active_Nxt;
    logic                 r_Done, w_Done_Nxt;
    logic                 w_Load, w_Clk_End, w_Has_Data;
`ifdef UART_TX_PARITY_EN
    logic                 r_Parity, w_Parity_Nxt;
`endif

    assign w_Clk_End  = (r_Clk_Cnt == CLK_LAST);
    assign w_Has_Data = (r_Count != '0);

    always_comb begin
        w_State_Nxt  = r_State;
        w_Clk_Nxt    = r_Clk_Cnt;
        w_Bit_Nxt    = r_Bit_Idx;
        w_Shift_Nxt  = r_Shift;
        w_Serial_Nxt = r_Serial;
        w_Active_Nxt = r_Active;
        w_Done_Nxt   = 1'b0;
        w_Load       = 1'b0;
        w_Pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_Parity_Nxt = r_Parity;
`endif
        unique case (r_State)
            S_IDLE: begin
                w_Serial_Nxt = 1'b1;
                w_Active_Nxt = 1'b0;
                w_Load       = w_Has_Data;
            end
            S_START: begin
                w_Clk_Nxt = r_Clk_Cnt + 1'b1;
                if (w_Clk_End) begin
                    w_Clk_Nxt    = '0;
                    w_Bit_Nxt    = '0;
                    w_Serial_Nxt = r_Shift[0];
                    w_State_Nxt  = S_DATA;
                end
            end
            S_DATA: begin
                w_Clk_Nxt = r_Clk_Cnt + 1'b1;
                if (w_Clk_End) begin
                    w_Clk_Nxt = '0;
                    if (r_Bit_Idx == DATA_LAST) begin
                        w_Bit_Nxt    = '0;
                        w_Serial_Nxt = 1'b1;
                        w_State_Nxt  = S_STOP;
`ifdef UART_TX_PARITY_EN
                        if (PARITY != 0) begin
                            w_Serial_Nxt = r_Parity;
                            w_State_Nxt  = S_PARITY;
                        end
`endif
                    end else begin
                        w_Bit_Nxt    = r_Bit_Idx + 1'b1;
                        w_Shift_Nxt  = r_Shift >> 1;
                        w_Serial_Nxt = r_Shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_Clk_Nxt = r_Clk_Cnt + 1'b1;
                if (w_Clk_End) begin
                    w_Clk_Nxt    = '0;
                    w_Bit_Nxt    = '0;
                    w_Serial_Nxt = 1'b1;
                    w_State_Nxt  = S_STOP;
                end
            end
`endif
            S_STOP: begin
                w_Clk_Nxt = r_Clk_Cnt + 1'b1;
                if (w_Clk_End) begin
                    w_Clk_Nxt = '0;
                    if (r_Bit_Idx == STOP_LAST) begin
                        // a queued character starts its start bit with no idle gap
                        w_Done_Nxt   = 1'b1;
                        w_Load       = w_Has_Data;
                        w_Active_Nxt = 1'b0;
                        w_State_Nxt  = S_IDLE;
                    end else begin
                        w_Bit_Nxt = r_Bit_Idx + 1'b1;
                    end
                end
            end
            default: w_State_Nxt = S_IDLE;
        endcase

        if (w_Load) begin
            w_Pop        = 1'b1;
            w_Shift_Nxt  = w_Head;
            w_Serial_Nxt = 1'b0;
            w_Active_Nxt = 1'b1;
            w_Clk_Nxt    = '0;
            w_Bit_Nxt    = '0;
            w_State_Nxt  = S_START;
`ifdef UART_TX_PARITY_EN
            w_Parity_Nxt = (^w_Head) ^ (PARITY == 2);
`endif
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_State   <= S_IDLE;
            r_Clk_Cnt <= '0;
            r_Bit_Idx <= '0;
            r_Shift   <= '0;
            r_Serial  <= 1'b1;
            r_Active  <= 1'b0;
            r_Done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_Parity  <= 1'b0;
`endif
        end else begin
            r_State   <= w_State_Nxt;
            r_Clk_Cnt <= w_Clk_Nxt;
            r_Bit_Idx <= w_Bit_Nxt;
            r_Shift   <= w_Shift_Nxt;
            r_Serial  <= w_Serial_Nxt;
            r_Active  <= w_Active_Nxt;
            r_Done    <= w_Done_Nxt;
`ifdef UART_TX_PARITY_EN
            r_Parity  <= w_Parity_Nxt;
`endif
        end
    end

    assign tx.o_Tx_Ready   = r_Ready;
    assign tx.o_Fifo_Count = r_Count;
    assign o_Tx_Active     = r_Active;
    assign o_Tx_Serial     = r_Serial;
    assign o_Tx_Done       = r_Done;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: two instances (8N/E/1 and 7/O/2) at 4 clocks per bit.
module tb_uart_tx_fifo;
    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_a ();
    uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if_b ();
    logic act_a, ser_a, done_a, act_b, ser_b, done_b;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1), .PARITY(1), .FIFO_DEPTH(4)) u_a (
        .i_Clock(clk), .i_Reset(rst_n), .tx(if_a),
        .o_Tx_Active(act_a), .o_Tx_Serial(ser_a), .o_Tx_Done(done_a));
    uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(7), .STOP_BITS(2), .PARITY(2), .FIFO_DEPTH(4)) u_b (
        .i_Clock(clk), .i_Reset(rst_n), .tx(if_b),
        .o_Tx_Active(act_b), .o_Tx_Serial(ser_b), .o_Tx_Done(done_b));

    int   sel = 0;
    logic ser, done, act;
    assign ser  = (sel != 0) ? ser_b  : ser_a;
    assign done = (sel != 0) ? done_b : done_a;
    assign act  = (sel != 0) ? act_b  : act_a;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int frame_len(input int nbits, input int par, input int nstop);
        return (1 + nbits + ((PAR_ON && par != 0) ? 1 : 0) + nstop) * C;
    endfunction

    // Advance to the first cycle of a start bit; n = negedges waited.
    task automatic wait_start(output int n);
        n = 0;
        while (ser !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("start_timeout", {31'd0, ser}, 32'd0);
    endtask

    // Called at the first start-bit sample; returns at the sample after the last stop cycle.
    task automatic frame_check(input string tag, input logic [8:0] data, input int nbits,
                               input int par, input int nstop);
        logic [15:0] bits;
        logic [3:0]  smp;
        int          nb;
        int          bad_act;
        int          done_seen;
        logic        p;
        nb = 0; bad_act = 0; done_seen = 0; p = 1'b0; bits = '0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < nbits; i++) begin
            bits[nb] = data[i]; nb++;
            p = p ^ data[i];
        end
        if (PAR_ON && par != 0) begin
            bits[nb] = p ^ (par == 2); nb++;
        end
        for (int i = 0; i < nstop; i++) begin
            bits[nb] = 1'b1; nb++;
        end
        for (int b = 0; b < nb; b++) begin
            smp = '0;
            for (int k = 0; k < C; k++) begin
                smp[k] = ser;
                if (act !== 1'b1) bad_act++;
                if ((b != 0 || k != 0) && done === 1'b1) done_seen++;
                @(negedge clk);
            end
            chk($sformatf("%s_bit%0d", tag, b), {28'd0, smp}, {28'd0, {4{bits[b]}}});
        end
        chk({tag, "_active"}, bad_act, 0);
        chk({tag, "_early_done"}, done_seen, 0);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n, bad, dn;
        if_a.i_Tx_DV = 1'b0; if_a.i_Tx_Byte = '0;
        if_b.i_Tx_DV = 1'b0; if_b.i_Tx_Byte = '0;
        repeat (3) @(negedge clk);
        chk("rst_ser",   {31'd0, ser_a}, 1);
        chk("rst_ready", {31'd0, if_a.o_Tx_Ready}, 1);
        chk("rst_count", {29'd0, if_a.o_Fifo_Count}, 0);
        chk("rst_active",{31'd0, act_a}, 0);
        chk("rst_done",  {31'd0, done_a}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single frame 0xA5, one-cycle write-to-start latency
        if_a.i_Tx_DV = 1'b1; if_a.i_Tx_Byte = 8'hA5;
        @(negedge clk);
        if_a.i_Tx_DV = 1'b0;
        chk("a5_cnt_queued", {29'd0, if_a.o_Fifo_Count}, 1);
        chk("a5_ser_before", {31'd0, ser_a}, 1);
        @(negedge clk);
        chk("a5_ser_start", {31'd0, ser_a}, 0);
        chk("a5_cnt_popped", {29'd0, if_a.o_Fifo_Count}, 0);
        frame_check("a5", 9'h0A5, 8, 1, 1);
        chk("a5_len44", frame_len(8, 1, 1), PAR_ON ? 44 : 40);
        chk("a5_idle_active", {31'd0, act_a}, 0);
        @(negedge clk);
        chk("a5_done_pulse", {31'd0, done_a}, 0);

        // 7-bit odd-parity, 2 stop bits: 0x07 then 0x55 back to back
        sel = 1;
        if_b.i_Tx_DV = 1'b1; if_b.i_Tx_Byte = 7'h07;
        @(negedge clk);
        if_b.i_Tx_Byte = 7'h55;
        @(negedge clk);
        if_b.i_Tx_DV = 1'b0;
        wait_start(n);
        chk("b_start_wait", n, 0);
        frame_check("b07", 9'h007, 7, 2, 2);
        wait_start(n);
        chk("b_contig", n, 0);
        frame_check("b55", 9'h055, 7, 2, 2);
        chk("b_idle_active", {31'd0, act_b}, 0);
        sel = 0;
        @(negedge clk);

        // six writes on consecutive cycles into a depth-4 FIFO
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    if (i == 4) chk("burst_ready_before5", {31'd0, if_a.o_Tx_Ready}, 1);
                    if (i == 5) begin
                        chk("burst_ready_full", {31'd0, if_a.o_Tx_Ready}, 0);
                        chk("burst_cnt_full", {29'd0, if_a.o_Fifo_Count}, 4);
                    end
                    if_a.i_Tx_DV = 1'b1; if_a.i_Tx_Byte = 8'h11 + 8'(i);
                end
                @(negedge clk);
                if_a.i_Tx_DV = 1'b0;
                chk("burst_drop_cnt", {29'd0, if_a.o_Fifo_Count}, 4);
            end
            begin
                wait_start(n);
                for (int f = 0; f < 5; f++) begin
                    if (f != 0) begin
                        wait_start(n);
                        chk($sformatf("burst_contig%0d", f), n, 0);
                    end
                    frame_check($sformatf("burst%0d", f), 9'h011 + 9'(f), 8, 1, 1);
                end
            end
        join
        chk("burst_end_active", {31'd0, act_a}, 0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (ser_a !== 1'b1 || act_a !== 1'b0) bad++;
        end
        chk("burst_sixth_dropped", bad, 0);

        // reset mid-DATA with two characters queued
        for (int i = 0; i < 3; i++) begin
            if_a.i_Tx_DV = 1'b1; if_a.i_Tx_Byte = (i == 0) ? 8'hF0 : 8'h0F;
            @(negedge clk);
        end
        if_a.i_Tx_DV = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_rst_ser", {31'd0, ser_a}, 0);
        chk("pre_rst_cnt", {29'd0, if_a.o_Fifo_Count}, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_ser", {31'd0, ser_a}, 1);
        chk("rst_mid_cnt", {29'd0, if_a.o_Fifo_Count}, 0);
        chk("rst_mid_ready", {31'd0, if_a.o_Tx_Ready}, 1);
        chk("rst_mid_active", {31'd0, act_a}, 0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a === 1'b1) dn++;
        end
        rst_n = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (ser_a !== 1'b1 || act_a !== 1'b0) bad++;
            if (done_a === 1'b1) dn++;
        end
        chk("rst_idle_line", bad, 0);
        chk("rst_no_done", dn, 0);
        if_a.i_Tx_DV = 1'b1; if_a.i_Tx_Byte = 8'h3C;
        @(negedge clk);
        if_a.i_Tx_DV = 1'b0;
        wait_start(n);
        chk("post_rst_latency", n, 1);
        frame_check("post_rst", 9'h03C, 8, 1, 1);
        @(negedge clk);

        // write during the final stop cycle with an empty FIFO
        if_a.i_Tx_DV = 1'b1; if_a.i_Tx_Byte = 8'h81;
        @(negedge clk);
        if_a.i_Tx_DV = 1'b0;
        @(negedge clk);
        fork
            frame_check("gap81", 9'h081, 8, 1, 1);
            begin
                repeat (frame_len(8, 1, 1) - 1) @(negedge clk);
                if_a.i_Tx_DV = 1'b1; if_a.i_Tx_Byte = 8'h42;
                @(negedge clk);
                if_a.i_Tx_DV = 1'b0;
            end
        join
        chk("gap_active", {31'd0, act_a}, 0);
        chk("gap_ser", {31'd0, ser_a}, 1);
        chk("gap_cnt", {29'd0, if_a.o_Fifo_Count}, 1);
        wait_start(n);
        chk("gap_len", n, 1);
        frame_check("gap42", 9'h042, 8, 1, 1);
        @(negedge clk);
        chk("gap_done_once", {31'd0, done_a}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
